// File: rtl/zion_riscv_isa_lib_add_sub_ex_stage.sv
// ---------------------------------------------------------------------------
// zion_riscv_isa_lib_add_sub_ex_stage
//
// Registered execute stage for the RV32I/RV64I add/sub class:
// ADD/ADDI, SUB, ADDW/ADDIW, SUBW, SLT[I][U].
// One operation is accepted per cycle. The result is presented through a
// 2-entry skid buffer (OUT + SKID), which sustains full throughput under
// downstream backpressure.
//
// Parameters
//   RV64   1 = 64-bit datapath (.W ops legal), 0 = 32-bit datapath
//   TAG_W  width of the pass-through tag (destination register index)
//
// Ports
//   iClk, iRst          clock, synchronous active-high reset
//   iValid / oReady     upstream handshake (oReady is registered)
//   iOp                 [0]=add [1]=sub [2]=.W (RV64 only)
//   iSltEn, iUnsigned   set-less-than select, unsigned compare
//   iS1, iS2, iTag      operands and pass-through tag
//   oValid / iReady     downstream handshake
//   oRslt, oLessThan    result and compare flag
//   oTag                tag of the presented result
//   oOpErr              sticky: an accepted op had add and sub both set
//
// State      | meaning
// -----------+------------------------------------------------
// ST_EMPTY   | OUT and SKID empty
// ST_ONE     | OUT holds a result, SKID empty
// ST_FULL    | OUT and SKID both hold results, oReady low
// ---------------------------------------------------------------------------
module zion_riscv_isa_lib_add_sub_ex_stage #(
  parameter int RV64  = 0,
  parameter int TAG_W = 5
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [RV64+1:0]           iOp,
  input  logic                      iSltEn,
  input  logic                      iUnsigned,
  input  logic [32*(RV64+1)-1:0]    iS1,
  input  logic [32*(RV64+1)-1:0]    iS2,
  input  logic [TAG_W-1:0]          iTag,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [32*(RV64+1)-1:0]    oRslt,
  output logic                      oLessThan,
  output logic [TAG_W-1:0]          oTag,
  output logic                      oOpErr
);

  localparam int CPU_WIDTH = 32 * (RV64 + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CPU_WIDTH-1:0] out_rslt_q;
  logic                 out_lt_q;
  logic [TAG_W-1:0]     out_tag_q;
  logic [CPU_WIDTH-1:0] skid_rslt_q;
  logic                 skid_lt_q;
  logic [TAG_W-1:0]     skid_tag_q;
  logic                 op_err_q;

  logic accept_w;
  logic release_w;
  logic load_out_new;
  logic load_out_skid;
  logic load_skid;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic                 op_add;
  logic                 op_sub;
  logic                 op_w;
  logic                 eff_sub;
  logic                 eff_add;
  logic [CPU_WIDTH-1:0] opnd_a;
  logic [CPU_WIDTH-1:0] opnd_b;
  logic [CPU_WIDTH-1:0] sum;
  logic [CPU_WIDTH-1:0] sum_w;
  logic                 lt;
  logic [CPU_WIDTH-1:0] rslt;

  assign op_add = iOp[0];
  assign op_sub = iOp[1];

  // The .W bit and the 32-bit sign extension only exist on the 64-bit build.
  generate
    if (RV64 != 0) begin : g_rv64
      assign op_w  = iOp[RV64+1];
      assign sum_w = {{32{sum[31]}}, sum[31:0]};
    end else begin : g_rv32
      assign op_w  = 1'b0;
      assign sum_w = sum;
    end
  endgenerate

  // SLT forces subtract; sub wins over add when both are set.
  assign eff_sub = op_sub | iSltEn;
  assign eff_add = op_add & ~eff_sub;
  assign opnd_a  = (eff_add | eff_sub) ? iS1 : '0;
  assign opnd_b  = eff_sub ? ~iS2 : (eff_add ? iS2 : '0);
  assign sum     = opnd_a + opnd_b + CPU_WIDTH'(eff_sub);

  // Differing MSBs decide the compare directly; otherwise the difference
  // cannot overflow and its sign is the answer. Always full width.
  always_comb begin
    lt = sum[CPU_WIDTH-1];
    if (iS1[CPU_WIDTH-1] != iS2[CPU_WIDTH-1]) begin
      lt = iUnsigned ? iS2[CPU_WIDTH-1] : iS1[CPU_WIDTH-1];
    end
  end

  always_comb begin
    rslt = sum;
    if (iSltEn) begin
      rslt = {{(CPU_WIDTH-1){1'b0}}, lt};
    end else if (op_w) begin
      rslt = sum_w;
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------
  assign oValid    = (state_q != ST_EMPTY);
  assign oReady    = (state_q != ST_FULL);
  assign accept_w  = iValid & oReady;
  assign release_w = oValid & iReady;

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_w) begin
          load_out_new = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_w && release_w) begin
          load_out_new = 1'b1;
        end else if (accept_w) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (release_w) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (release_w) begin
          load_out_skid = 1'b1;
          state_d       = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_EMPTY;
      out_rslt_q  <= '0;
      out_lt_q    <= 1'b0;
      out_tag_q   <= '0;
      skid_rslt_q <= '0;
      skid_lt_q   <= 1'b0;
      skid_tag_q  <= '0;
      op_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_out_new) begin
        out_rslt_q <= rslt;
        out_lt_q   <= lt;
        out_tag_q  <= iTag;
      end else if (load_out_skid) begin
        out_rslt_q <= skid_rslt_q;
        out_lt_q   <= skid_lt_q;
        out_tag_q  <= skid_tag_q;
      end
      if (load_skid) begin
        skid_rslt_q <= rslt;
        skid_lt_q   <= lt;
        skid_tag_q  <= iTag;
      end
      if (accept_w && op_add && op_sub) begin
        op_err_q <= 1'b1;
      end
    end
  end

  assign oRslt     = out_rslt_q;
  assign oLessThan = out_lt_q;
  assign oTag      = out_tag_q;
  assign oOpErr    = op_err_q;

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_ex_stage.sv
module tb_zion_riscv_isa_lib_add_sub_ex_stage;

  // index 0 = RV32 instance, index 1 = RV64 instance
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       vld;
  logic [1:0]       rdy_in;
  logic [1:0]       slt;
  logic [1:0]       uns;
  logic [1:0][2:0]  op;
  logic [1:0][63:0] s1;
  logic [1:0][63:0] s2;
  logic [1:0][4:0]  tag;
  logic [1:0]       ordy;
  logic [1:0]       ovld;
  logic [1:0]       olt;
  logic [1:0]       oerr;
  logic [1:0][4:0]  otag;
  logic [63:0]      rslt64;
  logic [31:0]      rslt32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zion_riscv_isa_lib_add_sub_ex_stage #(.RV64(0), .TAG_W(5)) u_dut32 (
    .iClk(clk), .iRst(rst), .iValid(vld[0]), .oReady(ordy[0]),
    .iOp(op[0][1:0]), .iSltEn(slt[0]), .iUnsigned(uns[0]),
    .iS1(s1[0][31:0]), .iS2(s2[0][31:0]), .iTag(tag[0]),
    .oValid(ovld[0]), .iReady(rdy_in[0]), .oRslt(rslt32),
    .oLessThan(olt[0]), .oTag(otag[0]), .oOpErr(oerr[0])
  );

  zion_riscv_isa_lib_add_sub_ex_stage #(.RV64(1), .TAG_W(5)) u_dut64 (
    .iClk(clk), .iRst(rst), .iValid(vld[1]), .oReady(ordy[1]),
    .iOp(op[1]), .iSltEn(slt[1]), .iUnsigned(uns[1]),
    .iS1(s1[1]), .iS2(s2[1]), .iTag(tag[1]),
    .oValid(ovld[1]), .iReady(rdy_in[1]), .oRslt(rslt64),
    .oLessThan(olt[1]), .oTag(otag[1]), .oOpErr(oerr[1])
  );

  function automatic logic [63:0] rslt_of(input bit d);
    return d ? rslt64 : {32'd0, rslt32};
  endfunction

  // Reference: plain arithmetic on the architectural meaning of each op.
  // Returns {compare_meaningful, lt, result}.
  function automatic logic [65:0] ref_model(input bit d, input logic [2:0] o,
                                            input logic sl, input logic un,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, s, r;
    logic l, sub, add;
    x   = d ? a : {32'd0, a[31:0]};
    y   = d ? b : {32'd0, b[31:0]};
    sub = o[1] | sl;
    add = o[0] & ~sub;
    if (d) l = un ? (x < y) : ($signed(x) < $signed(y));
    else   l = un ? (x[31:0] < y[31:0]) : ($signed(x[31:0]) < $signed(y[31:0]));
    s = sub ? (x - y) : (add ? (x + y) : 64'd0);
    if (!d) s[63:32] = 32'd0;
    if (sl)              r = {63'd0, l};
    else if (d && o[2])  r = {{32{s[31]}}, s[31:0]};
    else                 r = s;
    return {sub, l, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit d, input logic [2:0] o, input logic sl, input logic un,
                     input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    vld[d] = 1'b1; op[d] = o; slt[d] = sl; uns[d] = un;
    s1[d] = a; s2[d] = b; tag[d] = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 2'b11;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ovld[d] !== 1'b0 || ordy[d] !== 1'b1 || oerr[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: valid=%b ready=%b err=%b required 0 1 0", d, ovld[d], ordy[d], oerr[d]);
      end
      checks++;
      if (rslt_of(d[0]) !== 64'd0 || olt[d] !== 1'b0 || otag[d] !== 5'd0) begin
        errors++;
        $display("FAIL reset_data dut%0d: rslt=%h lt=%b tag=%0d required 0", d, rslt_of(d[0]), olt[d], otag[d]);
      end
    end
    vld = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_rv64_w();
    rdy_in[1] = 1'b1;
    put(1, 3'b101, 0, 0, 64'h7FFF_FFFF, 64'h1, 5'd3);
    step();
    vld[1] = 1'b0;
    checks++;
    if (ovld[1] !== 1'b1 || rslt64 !== 64'hFFFF_FFFF_8000_0000 || otag[1] !== 5'd3) begin
      errors++;
      $display("FAIL addw: valid=%b rslt=%h tag=%0d required 1 ffffffff80000000 3", ovld[1], rslt64, otag[1]);
    end
    put(1, 3'b001, 0, 0, 64'h7FFF_FFFF, 64'h1, 5'd4);
    step();
    vld[1] = 1'b0;
    checks++;
    if (rslt64 !== 64'h0000_0000_8000_0000 || otag[1] !== 5'd4) begin
      errors++;
      $display("FAIL add64: rslt=%h tag=%0d required 0000000080000000 4", rslt64, otag[1]);
    end
    // SUBW: low word sign-extended, compare still on full 64-bit operands
    put(1, 3'b110, 0, 0, 64'h1_0000_0000, 64'h1, 5'd5);
    step();
    vld[1] = 1'b0;
    checks++;
    if (rslt64 !== 64'hFFFF_FFFF_FFFF_FFFF || olt[1] !== 1'b0) begin
      errors++;
      $display("FAIL subw: rslt=%h lt=%b required ffffffffffffffff 0", rslt64, olt[1]);
    end
    step();
  endtask

  task automatic test_rv32_slt();
    logic [31:0] exp_r [4];
    logic        exp_l [4];
    logic [2:0]  ops   [4];
    logic        sls   [4];
    logic        uss   [4];
    logic [63:0] as    [4];
    logic [63:0] bs    [4];
    exp_r = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'd0};
    exp_l = '{1'b1, 1'b0, 1'b1, 1'b0};
    ops   = '{3'b000, 3'b000, 3'b010, 3'b000};
    sls   = '{1'b1, 1'b1, 1'b0, 1'b0};
    uss   = '{1'b0, 1'b1, 1'b0, 1'b0};
    as    = '{64'h8000_0000, 64'h8000_0000, 64'd5, 64'd5};
    bs    = '{64'd1, 64'd1, 64'd7, 64'd7};
    rdy_in[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(0, ops[i], sls[i], uss[i], as[i], bs[i], 5'(i + 10));
      step();
      vld[0] = 1'b0;
      checks++;
      if (ovld[0] !== 1'b1 || rslt32 !== exp_r[i] || otag[0] !== 5'(i + 10)) begin
        errors++;
        $display("FAIL rv32_case%0d: valid=%b rslt=%h tag=%0d required 1 %h %0d", i, ovld[0], rslt32, otag[0], exp_r[i], i + 10);
      end
      if (i < 3) begin
        checks++;
        if (olt[0] !== exp_l[i]) begin
          errors++;
          $display("FAIL rv32_lt%0d: lt=%b required %b", i, olt[0], exp_l[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    rdy_in[1] = 1'b0;
    put(1, 3'b001, 0, 0, 64'd100, 64'd1, 5'd1);
    step();
    checks++;
    if (ovld[1] !== 1'b1 || otag[1] !== 5'd1 || ordy[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%b tag=%0d ready=%b required 1 1 1", ovld[1], otag[1], ordy[1]);
    end
    put(1, 3'b001, 0, 0, 64'd200, 64'd2, 5'd2);
    step();
    checks++;
    if (ordy[1] !== 1'b0 || otag[1] !== 5'd1 || rslt64 !== 64'd101) begin
      errors++;
      $display("FAIL bp_full: ready=%b tag=%0d rslt=%0d required 0 1 101", ordy[1], otag[1], rslt64);
    end
    put(1, 3'b001, 0, 0, 64'd300, 64'd3, 5'd3);
    step();
    checks++;
    if (ordy[1] !== 1'b0 || otag[1] !== 5'd1 || rslt64 !== 64'd101) begin
      errors++;
      $display("FAIL bp_hold: ready=%b tag=%0d rslt=%0d required 0 1 101", ordy[1], otag[1], rslt64);
    end
    rdy_in[1] = 1'b1;
    step();
    checks++;
    if (ovld[1] !== 1'b1 || otag[1] !== 5'd2 || rslt64 !== 64'd202 || ordy[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain2: valid=%b tag=%0d rslt=%0d ready=%b required 1 2 202 1", ovld[1], otag[1], rslt64, ordy[1]);
    end
    step();
    vld[1] = 1'b0;
    checks++;
    if (ovld[1] !== 1'b1 || otag[1] !== 5'd3 || rslt64 !== 64'd303) begin
      errors++;
      $display("FAIL bp_drain3: valid=%b tag=%0d rslt=%0d required 1 3 303", ovld[1], otag[1], rslt64);
    end
    step();
    checks++;
    if (ovld[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b required 0", ovld[1]);
    end
  endtask

  task automatic test_stream(input bit d, input int n, input bit bp);
    logic [65:0] expq[$];
    logic [4:0]  tagq[$];
    logic [63:0] a, b;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc, rel;
    while (got < n && cyc < 4000) begin
      if (sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) b = a;
        if ($urandom_range(0, 3) == 0) b[63] = ~a[63];
        put(d, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            a, b, 5'($urandom));
      end else begin
        vld[d] = 1'b0;
      end
      rdy_in[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bp) begin
        checks++;
        if (ordy[d] !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready dut%0d cycle %0d: ready=%b required 1", d, cyc, ordy[d]);
        end
      end
      acc = vld[d] && ordy[d];
      rel = ovld[d] && rdy_in[d];
      if (rel) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stream_extra dut%0d: tag=%0d required no output", d, otag[d]);
        end else begin
          if (rslt_of(d) !== expq[0][63:0] || otag[d] !== tagq[0] ||
              (expq[0][65] && olt[d] !== expq[0][64])) begin
            errors++;
            $display("FAIL stream_rslt dut%0d #%0d: rslt=%h lt=%b tag=%0d required %h %b %0d",
                     d, got, rslt_of(d), olt[d], otag[d], expq[0][63:0], expq[0][64], tagq[0]);
          end
          void'(expq.pop_front());
          void'(tagq.pop_front());
        end
        got++;
      end
      if (acc) begin
        expq.push_back(ref_model(d, op[d], slt[d], uns[d], s1[d], s2[d]));
        tagq.push_back(tag[d]);
        sent++;
      end
      step();
      cyc++;
    end
    vld[d] = 1'b0;
    rdy_in[d] = 1'b1;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL stream_count dut%0d: got %0d results required %0d", d, got, n);
    end
    step();
    step();
  endtask

  task automatic test_op_err();
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    rdy_in[1] = 1'b1;
    put(1, 3'b011, 0, 0, a, b, 5'd9);
    step();
    vld[1] = 1'b0;
    checks++;
    if (oerr[1] !== 1'b1 || rslt64 !== a - b) begin
      errors++;
      $display("FAIL op_err: err=%b rslt=%h required 1 %h", oerr[1], rslt64, a - b);
    end
    step();
    step();
    step();
    checks++;
    if (oerr[1] !== 1'b1) begin
      errors++;
      $display("FAIL op_err_sticky: err=%b required 1", oerr[1]);
    end
  endtask

  task automatic test_reset_full();
    rdy_in[1] = 1'b0;
    put(1, 3'b001, 0, 0, 64'd7, 64'd0, 5'd7);
    step();
    put(1, 3'b001, 0, 0, 64'd8, 64'd0, 5'd8);
    step();
    checks++;
    if (ordy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_prefill: ready=%b required 0", ordy[1]);
    end
    put(1, 3'b011, 0, 0, 64'd9, 64'd0, 5'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld[1] = 1'b0;
    checks++;
    if (ovld[1] !== 1'b0 || ordy[1] !== 1'b1 || oerr[1] !== 1'b0 || otag[1] !== 5'd0) begin
      errors++;
      $display("FAIL rst_full: valid=%b ready=%b err=%b tag=%0d required 0 1 0 0", ovld[1], ordy[1], oerr[1], otag[1]);
    end
    rdy_in[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ovld[1] !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale cycle %0d: valid=%b tag=%0d required valid 0", i, ovld[1], otag[1]);
      end
    end
  endtask

  initial begin
    vld = '0; rdy_in = '1; slt = '0; uns = '0;
    op = '0; s1 = '0; s2 = '0; tag = '0;
    rst = 1'b1;
    test_reset();
    test_rv64_w();
    test_rv32_slt();
    test_back_to_back();
    test_stream(1, 100, 0);
    test_stream(0, 100, 0);
    test_stream(0, 150, 1);
    test_stream(1, 150, 1);
    test_op_err();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
